// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the F stage and imem.
// Master issues req/addr; slave returns rdata/ready.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS32 F stage: PC register, imem request handshake and F/D register.
// Handles taken-branch delay slots plus eret/exception flushes.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    PCselF,
    input  logic [31:0]   NPC,
    input  logic [31:0]   EPC,
    input  logic          StallF,
    fetch_stage_if.master imem,
    output logic [31:0]   InstrD,
    output logic [31:0]   PCD,
    output logic [31:0]   PC4D,
    output logic          ValidD,
    output logic          AdELD
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic [31:0] r_pc;
    logic        r_pend_valid;
    logic [31:0] r_pend_pc;
    logic        r_discard;
    logic [31:0] r_daddr;
    logic [31:0] r_buf;
    logic [31:0] r_instr;
    logic [31:0] r_pcd;
    logic [31:0] r_pc4d;
    logic        r_valid;
    logic        r_adel;

    logic        w_flush;
    logic [31:0] w_flush_pc;
    logic        w_mis;
    logic        w_req;
    logic        w_ready;
    logic        w_take;
    logic        w_load;
    logic        w_to_hold;
    logic        w_capture;
    logic [31:0] w_pc4;
    logic [31:0] w_next_pc;
    logic [31:0] w_instr;

    assign w_flush    = PCselF[1];
    assign w_flush_pc = PCselF[0] ? HANDLER_PC : EPC;
    assign w_mis      = (r_pc[1:0] != 2'b00);
    assign w_pc4      = r_pc + 32'd4;

    // A dropped-word wait keeps the old request alive on the bus.
    assign w_req   = (r_state == S_FETCH) && (r_discard || !w_mis);
    assign w_ready = w_req && imem.imem_ready;

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_discard ? r_daddr : r_pc;

    assign w_take = (r_state == S_HOLD) ||
                    ((r_state == S_FETCH) && !r_discard &&
                     (w_mis || w_ready));

    assign w_load    = w_take && !StallF && !w_flush;
    assign w_to_hold = (r_state == S_FETCH) && !r_discard && !w_mis &&
                       w_ready && StallF && !w_flush;
    assign w_capture = (PCselF == 2'b01) && r_valid && !StallF;

    // A branch resolving as its delay slot is accepted goes straight to NPC.
    assign w_next_pc = w_capture    ? NPC :
                       r_pend_valid ? r_pend_pc : w_pc4;

    always_comb begin
        w_instr = 32'd0;
        unique case (1'b1)
            (r_state == S_HOLD): w_instr = r_buf;
            w_mis:               w_instr = 32'd0;
            default:             w_instr = imem.imem_rdata;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE:  w_state_nx = S_FETCH;
            S_FETCH: w_state_nx = w_to_hold ? S_HOLD : S_FETCH;
            S_HOLD:  if (w_flush || !StallF) w_state_nx = S_FETCH;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= 32'd0;
        end else if (w_flush) begin
            r_pc         <= w_flush_pc;
            r_pend_valid <= 1'b0;
        end else if (w_load) begin
            r_pc         <= w_next_pc;
            r_pend_valid <= 1'b0;
        end else if (w_capture) begin
            r_pend_valid <= 1'b1;
            r_pend_pc    <= NPC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_discard <= 1'b0;
            r_daddr   <= 32'd0;
            r_buf     <= 32'd0;
        end else begin
            if (w_flush && w_req && !imem.imem_ready) begin
                r_discard <= 1'b1;
                r_daddr   <= imem.imem_addr;
            end else if (r_discard && imem.imem_ready) begin
                r_discard <= 1'b0;
            end
            if (w_to_hold) begin
                r_buf <= imem.imem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= 32'd0;
            r_pcd   <= 32'd0;
            r_pc4d  <= 32'd0;
            r_valid <= 1'b0;
            r_adel  <= 1'b0;
        end else if (w_flush || (!w_load && !StallF)) begin
            r_instr <= 32'd0;
            r_valid <= 1'b0;
            r_adel  <= 1'b0;
        end else if (w_load) begin
            r_instr <= w_instr;
            r_pcd   <= r_pc;
            r_pc4d  <= w_pc4;
            r_valid <= 1'b1;
            r_adel  <= (r_state == S_FETCH) && w_mis;
        end
    end

    assign InstrD = r_instr;
    assign PCD    = r_pcd;
    assign PC4D   = r_pc4d;
    assign ValidD = r_valid;
    assign AdELD  = r_adel;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [1:0]  PCselF;
    logic [31:0] NPC;
    logic [31:0] EPC;
    logic        StallF;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PC4D;
    logic        ValidD;
    logic        AdELD;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .PCselF (PCselF),
        .NPC    (NPC),
        .EPC    (EPC),
        .StallF (StallF),
        .imem   (bus.master),
        .InstrD (InstrD),
        .PCD    (PCD),
        .PC4D   (PC4D),
        .ValidD (ValidD),
        .AdELD  (AdELD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: fetch progress, held word, lost (abandoned) request, D slot.
    logic        m_started;
    logic [31:0] m_pc;
    logic        m_tv;
    logic [31:0] m_tgt;
    logic        m_lost;
    logic [31:0] m_laddr;
    logic        m_held;
    logic [31:0] m_hword;
    logic        m_dv;
    logic        m_dadel;
    logic [31:0] m_dinstr;
    logic [31:0] m_dpc;
    logic [31:0] m_dpc4;

    logic        c_req;
    logic [31:0] c_addr;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_started = 1'b0;
        m_pc      = 32'h0000_3000;
        m_tv      = 1'b0;
        m_tgt     = 32'd0;
        m_lost    = 1'b0;
        m_laddr   = 32'd0;
        m_held    = 1'b0;
        m_hword   = 32'd0;
        m_dv      = 1'b0;
        m_dadel   = 1'b0;
        m_dinstr  = 32'd0;
        m_dpc     = 32'd0;
        m_dpc4    = 32'd0;
    endfunction

    function automatic logic exp_req();
        return m_started && !m_held && (m_lost || (m_pc[1:0] == 2'b00));
    endfunction

    function automatic void d_bubble();
        m_dv     = 1'b0;
        m_dadel  = 1'b0;
        m_dinstr = 32'd0;
    endfunction

    function automatic void model_step();
        logic        rq;
        logic        rdy;
        logic        avail;
        logic        adel_item;
        logic        br;
        logic [31:0] word;
        rq        = exp_req();
        rdy       = bus.imem_ready;
        br        = (PCselF == 2'b01) && m_dv && !StallF;
        avail     = 1'b0;
        adel_item = 1'b0;
        word      = 32'd0;
        if (m_held) begin
            avail = 1'b1;
            word  = m_hword;
        end else if (m_started && !m_lost && m_pc[1:0] != 2'b00) begin
            avail     = 1'b1;
            adel_item = 1'b1;
        end else if (m_started && !m_lost && rq && rdy) begin
            avail = 1'b1;
            word  = bus.imem_rdata;
        end
        if (PCselF[1]) begin
            if (rq && !rdy) begin
                if (!m_lost) m_laddr = m_pc;
                m_lost = 1'b1;
            end else begin
                m_lost = 1'b0;
            end
            m_pc   = PCselF[0] ? 32'h0000_4180 : EPC;
            m_tv   = 1'b0;
            m_held = 1'b0;
            d_bubble();
        end else begin
            if (m_lost && rdy) m_lost = 1'b0;
            if (avail && !StallF) begin
                m_dv     = 1'b1;
                m_dadel  = adel_item;
                m_dinstr = word;
                m_dpc    = m_pc;
                m_dpc4   = m_pc + 32'd4;
                m_pc     = br ? NPC : (m_tv ? m_tgt : m_pc + 32'd4);
                m_tv     = 1'b0;
                m_held   = 1'b0;
            end else begin
                if (avail && StallF && !m_held && !adel_item) begin
                    m_held  = 1'b1;
                    m_hword = word;
                end
                if (br) begin
                    m_tv  = 1'b1;
                    m_tgt = NPC;
                end
                if (!StallF) d_bubble();
            end
        end
        m_started = 1'b1;
    endfunction

    task automatic check_comb();
        chk("imem_req", {31'd0, bus.imem_req}, {31'd0, exp_req()});
        if (exp_req())
            chk("imem_addr", bus.imem_addr, m_lost ? m_laddr : m_pc);
    endtask

    task automatic check_regs();
        chk("ValidD", {31'd0, ValidD}, {31'd0, m_dv});
        chk("AdELD", {31'd0, AdELD}, {31'd0, m_dadel});
        chk("InstrD", InstrD, m_dinstr);
        if (m_dv) begin
            chk("PCD", PCD, m_dpc);
            chk("PC4D", PC4D, m_dpc4);
        end
    endtask

    task automatic step(input logic st, input logic [1:0] sel,
                        input logic [31:0] npc, input logic [31:0] epc,
                        input logic rdy, input logic [31:0] rd);
        StallF         = st;
        PCselF         = sel;
        NPC            = npc;
        EPC            = epc;
        bus.imem_ready = rdy;
        bus.imem_rdata = rd;
        #1;
        c_req  = bus.imem_req;
        c_addr = bus.imem_addr;
        check_comb();
        model_step();
        @(posedge clk);
        #1;
        check_regs();
    endtask

    initial begin
        logic [31:0] r_npc;
        logic [31:0] r_epc;
        logic [1:0]  r_sel;
        int          r;
        rst_n          = 1'b0;
        PCselF         = 2'b00;
        NPC            = 32'd0;
        EPC            = 32'd0;
        StallF         = 1'b0;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'd0;
        model_reset();
        #12;
        chk("rst imem_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst InstrD", InstrD, 32'd0);
        chk("rst PCD", PCD, 32'd0);
        chk("rst PC4D", PC4D, 32'd0);
        chk("rst ValidD", {31'd0, ValidD}, 32'd0);
        chk("rst AdELD", {31'd0, AdELD}, 32'd0);
        rst_n = 1'b1;

        // zero-wait stream, then taken branch with delay slot
        step(0, 0, 0, 0, 1, 32'h0);
        chk("idle req", {31'd0, c_req}, 32'd0);
        step(0, 0, 0, 0, 1, 32'h3000);
        chk("addr0", c_addr, 32'h3000);
        chk("D0 instr", InstrD, 32'h3000);
        chk("D0 valid", {31'd0, ValidD}, 32'd1);
        step(0, 0, 0, 0, 1, 32'h3004);
        chk("addr1", c_addr, 32'h3004);
        step(0, 1, 32'h3100, 0, 1, 32'h3008);
        chk("addr2", c_addr, 32'h3008);
        chk("delay slot PCD", PCD, 32'h3008);
        step(0, 0, 0, 0, 1, 32'h3100);
        chk("target addr", c_addr, 32'h3100);
        chk("target PCD", PCD, 32'h3100);
        chk("target valid", {31'd0, ValidD}, 32'd1);

        // slow imem, then stall into HOLD
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 1, 32'hAAAA_0001);
        step(1, 0, 0, 0, 0, 32'h0);
        chk("hold no req", {31'd0, c_req}, 32'd0);
        step(0, 0, 0, 0, 0, 32'h0);
        chk("hold release instr", InstrD, 32'hAAAA_0001);
        chk("hold release PCD", PCD, 32'h3104);

        // exception during a 2-wait fetch
        step(0, 0, 0, 0, 0, 32'h0);
        step(0, 3, 0, 0, 0, 32'h0);
        chk("flush valid", {31'd0, ValidD}, 32'd0);
        step(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("discard addr", c_addr, 32'h3108);
        step(0, 0, 0, 0, 1, 32'h4180);
        chk("handler addr", c_addr, 32'h4180);
        chk("handler PCD", PCD, 32'h4180);

        // eret to a misaligned address
        step(0, 2, 0, 32'h3022, 1, 32'h1111_1111);
        step(0, 0, 0, 0, 0, 32'h0);
        chk("adel req", {31'd0, c_req}, 32'd0);
        chk("adel PCD", PCD, 32'h3022);
        chk("adel flag", {31'd0, AdELD}, 32'd1);
        chk("adel valid", {31'd0, ValidD}, 32'd1);
        step(0, 0, 0, 0, 0, 32'h0);
        chk("adel next PCD", PCD, 32'h3026);

        // async reset while in HOLD
        step(0, 3, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 1, 32'h1234_5678);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid rst req", {31'd0, bus.imem_req}, 32'd0);
        chk("mid rst valid", {31'd0, ValidD}, 32'd0);
        chk("mid rst instr", InstrD, 32'd0);
        chk("mid rst PCD", PCD, 32'd0);
        chk("mid rst PC4D", PC4D, 32'd0);
        chk("mid rst AdELD", {31'd0, AdELD}, 32'd0);
        model_reset();
        StallF = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 1, 32'h0);
        step(0, 0, 0, 0, 1, 32'h3000);
        chk("restart addr", c_addr, 32'h3000);

        // PC+4 wrap
        step(0, 2, 0, 32'hFFFF_FFFC, 1, 32'h0);
        step(0, 0, 0, 0, 1, 32'h5555_5555);
        chk("wrap addr", c_addr, 32'hFFFF_FFFC);
        chk("wrap PC4D", PC4D, 32'h0);
        step(0, 0, 0, 0, 1, 32'h6666_6666);
        chk("wrap next addr", c_addr, 32'h0);

        for (int i = 0; i < 4000; i++) begin
            r     = $urandom_range(0, 99);
            r_sel = (r < 3) ? 2'd3 : (r < 7) ? 2'd2 : (r < 17) ? 2'd1 : 2'd0;
            r_npc = 32'h0000_3000 | ($urandom & 32'h0000_0FFC);
            r_epc = 32'h0000_3000 | ($urandom & 32'h0000_0FFC);
            if ($urandom_range(0, 4) == 0) r_epc[1:0] = 2'($urandom_range(1, 3));
            step($urandom_range(0, 3) == 0, r_sel, r_npc, r_epc,
                 $urandom_range(0, 9) < 6, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
